cont_updown_modn: RTL and testbench
===================================

CONT_UPDOWN_MODN -- requirements
Module: cont_updown_modn

Interface
REQ-001 The block SHALL expose parameter MOD, default 10, giving the per-digit modulus, legal range 2..16.
REQ-002 The block SHALL expose parameter DIGITS, default 4, giving the number of cascaded digits, legal range 1..8.
REQ-003 The block SHALL derive localparam W = clog2(MOD) as the per-digit width, and SHALL NOT expose it as a port-sizing input.
REQ-004 clk  input  1  single clock; all state updates on the falling edge.
REQ-005 clr_n  input  1  reset; synchronous, active-low.
REQ-006 en  input  1  count enable for digit 0.
REQ-007 up_d  input  1  direction; 1 = up, 0 = down.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 din  input  DIGITS*W  load value; digit i occupies bits [i*W +: W].
REQ-010 cnt  output  DIGITS*W  registered count; digit i occupies bits [i*W +: W].
REQ-011 tc  output  1  combinational: every digit is at its terminal value for the current up_d (MOD-1 when up, 0 when down); independent of en.
REQ-012 co  output  1  combinational cascade carry, equal to tc & en.
REQ-013 ovf  output  1  registered one-cycle pulse marking a full-range wrap.

Function
REQ-014 Update priority on each falling clk edge SHALL be clr_n low > load high > en high > hold.
REQ-015 When en is low and load is low, cnt and all internal state SHALL hold their values; the count SHALL NOT return to zero.
REQ-016 Digit 0 SHALL step when en=1.
REQ-017 Digit i (i>0) SHALL step when en=1 and every lower digit is at its terminal value for the current up_d.
REQ-018 Up step: a digit at MOD-1 SHALL wrap to 0; otherwise it SHALL increment by 1.
REQ-019 Down step: a digit at 0 SHALL wrap to MOD-1; otherwise it SHALL decrement by 1.
REQ-020 A change of up_d SHALL take effect on the next edge, with no pipeline delay.
REQ-021 On load, each digit SHALL take its din field, saturated to MOD-1 if the field is greater than or equal to MOD.
REQ-022 load SHALL override en on the same edge, and ovf SHALL be 0 after a load edge.
REQ-023 ovf SHALL be 1 for exactly the cycle following an edge on which co=1 and the counter wrapped (all digits to 0 when up, all digits to MOD-1 when down), and 0 otherwise.
REQ-024 cnt SHALL never hold a digit value greater than or equal to MOD.
REQ-025 When MOD is a power of two, the behaviour SHALL be identical to a plain binary counter of DIGITS*W bits.

Reset
REQ-026 When clr_n=0 at a falling clk edge, cnt SHALL become all zeros and ovf SHALL become 0.
REQ-027 Reset SHALL dominate load and en asserted on the same edge.
REQ-028 A reset in mid-count SHALL take effect on that edge, with no partial-digit update.
REQ-029 tc and co SHALL follow the reset value of cnt: tc=1 after reset when up_d=0.

Structure
REQ-030 A shared package/include SHALL hold the MOD and DIGITS defaults, their legal limits, and the clog2 helper.
REQ-031 The digit SHALL be the sub-module cont_digit.
REQ-032 cont_digit SHALL have ports clk, clr_n, load, d, step, up_d, q and term.
REQ-033 cont_updown_modn SHALL instantiate DIGITS copies of cont_digit via generate, chaining term into the step enable of the next digit.
REQ-034 Out-of-range parameters SHALL be rejected at elaboration.

Verification (MOD=10, DIGITS=4)
REQ-035 Reset, en=1, up_d=1, 10 edges -> cnt=0010; tc=0 throughout.
REQ-036 Load din=9999, up_d=1, en=1 -> tc=1 and co=1; next edge cnt=0000 with ovf=1 for one cycle; following edge cnt=0001 and ovf=0.
REQ-037 From 0000, up_d=0, en=1, one edge -> cnt=9999 with ovf pulse; next edge cnt=9998.
REQ-038 Load din=0x12F4 -> cnt=12 9 4 (saturated digit); en=0 for 5 edges -> cnt unchanged.
REQ-039 Count to 0457, then assert clr_n=0 together with load=1 and en=1 -> next edge cnt=0000 and ovf=0.
REQ-040 At 0199 up, toggle up_d to 0 on the wrap edge -> cnt=0198; no ovf.

Source files
------------

// File: rtl/cont_updown_modn_pkg.sv
// Shared defaults, legal parameter limits and width helper for the
// cascaded modulo-N up/down counter.
package cont_updown_modn_pkg;

    localparam int MOD_DEFAULT    = 10;
    localparam int DIGITS_DEFAULT = 4;
    localparam int MOD_MIN        = 2;
    localparam int MOD_MAX        = 16;
    localparam int DIGITS_MIN     = 1;
    localparam int DIGITS_MAX     = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cont_digit.sv
// One modulo-MOD up/down digit. Updates on the falling edge. Priority is
// clear, then load, then step. term flags the wrap value for the current direction.
module cont_digit
    import cont_updown_modn_pkg::*;
#(
    parameter  int MOD = MOD_DEFAULT,
    localparam int W   = clog2(MOD)
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         step,
    input  logic         up_d,
    output logic [W-1:0] q,
    output logic         term
);

    localparam logic [W-1:0] TOP  = W'(MOD - 1);
    localparam logic [W-1:0] ONE  = W'(1);
    localparam logic [W:0]   MODV = (W + 1)'(MOD);

    // Load fields at or above the modulus clamp to the largest legal digit.
    function automatic logic [W-1:0] sat_digit(input logic [W-1:0] v);
        return ({1'b0, v} >= MODV) ? TOP : v;
    endfunction

    function automatic logic [W-1:0] next_digit(input logic [W-1:0] v,
                                                input logic         dir);
        if (dir) begin
            return (v == TOP) ? '0 : v + ONE;
        end else begin
            return (v == '0) ? TOP : v - ONE;
        end
    endfunction

    always_ff @(negedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else if (load) begin
            q <= sat_digit(d);
        end else if (step) begin
            q <= next_digit(q, up_d);
        end
    end

    assign term = up_d ? (q == TOP) : (q == '0);

endmodule

// File: rtl/cont_updown_modn.sv
// Cascaded DIGITS-digit modulo-MOD up/down counter with terminal count,
// cascade carry and a registered full-range wrap pulse.
module cont_updown_modn
    import cont_updown_modn_pkg::*;
#(
    parameter  int MOD    = MOD_DEFAULT,
    parameter  int DIGITS = DIGITS_DEFAULT,
    localparam int W      = clog2(MOD)
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic                up_d,
    input  logic                load,
    input  logic [DIGITS*W-1:0] din,
    output logic [DIGITS*W-1:0] cnt,
    output logic                tc,
    output logic                co,
    output logic                ovf
);

    if (MOD < MOD_MIN || MOD > MOD_MAX) begin : g_bad_mod
        $error("cont_updown_modn: MOD=%0d outside %0d..%0d", MOD, MOD_MIN, MOD_MAX);
    end
    if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
        $error("cont_updown_modn: DIGITS=%0d outside %0d..%0d", DIGITS, DIGITS_MIN, DIGITS_MAX);
    end

    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] term;

    // A digit steps only when every lower digit is about to wrap.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_first
            assign step[i] = en;
        end else begin : g_chain
            assign step[i] = step[i-1] & term[i-1];
        end

        cont_digit #(
            .MOD (MOD)
        ) u_digit (
            .clk   (clk),
            .clr_n (clr_n),
            .load  (load),
            .d     (din[i*W +: W]),
            .step  (step[i]),
            .up_d  (up_d),
            .q     (cnt[i*W +: W]),
            .term  (term[i])
        );
    end

    assign tc = &term;
    assign co = tc & en;

    // co=1 means every digit wraps on this edge, so it marks a full-range wrap.
    always_ff @(negedge clk) begin
        if (!clr_n) begin
            ovf <= 1'b0;
        end else if (load) begin
            ovf <= 1'b0;
        end else begin
            ovf <= co;
        end
    end

endmodule

// File: tb/tb_cont_updown_modn.sv
// Bench for cont_updown_modn (MOD=10, DIGITS=4): integer-valued reference
// model compared every cycle, plus directed literal expectations.
module tb_cont_updown_modn;

    localparam int MOD    = 10;
    localparam int DIGITS = 4;
    localparam int N      = 10000;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        en = 1'b0;
    logic        up_d = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] cnt;
    logic        tc;
    logic        co;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    int m_val = 0;
    bit m_ovf = 1'b0;
    bit m_valid = 1'b0;

    cont_updown_modn #(
        .MOD    (MOD),
        .DIGITS (DIGITS)
    ) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (en),
        .up_d  (up_d),
        .load  (load),
        .din   (din),
        .cnt   (cnt),
        .tc    (tc),
        .co    (co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int load_value(input logic [15:0] d);
        int v;
        int w;
        int f;
        v = 0;
        w = 1;
        for (int i = 0; i < DIGITS; i++) begin
            f = int'(d[i*4 +: 4]);
            if (f >= MOD) f = MOD - 1;
            v = v + f * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference: the count is a single integer modulo 10^DIGITS.
    initial begin
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                m_val = 0;
                m_ovf = 1'b0;
                m_valid = 1'b1;
            end else if (load) begin
                m_val = load_value(din);
                m_ovf = 1'b0;
            end else if (en) begin
                if (up_d) begin
                    m_ovf = (m_val == N - 1);
                    m_val = (m_val + 1) % N;
                end else begin
                    m_ovf = (m_val == 0);
                    m_val = (m_val + N - 1) % N;
                end
            end else begin
                m_ovf = 1'b0;
            end
        end
    end

    initial begin
        bit exp_tc;
        forever begin
            @(posedge clk);
            #3;
            if (m_valid) begin
                exp_tc = up_d ? (m_val == N - 1) : (m_val == 0);
                chk("model_cnt", 32'(cnt), 32'(to_bcd(m_val)));
                chk("model_ovf", 32'(ovf), 32'(m_ovf));
                chk("model_tc",  32'(tc),  32'(exp_tc));
                chk("model_co",  32'(co),  32'(exp_tc & en));
            end
        end
    end

    task automatic step(input logic c, input logic l, input logic e,
                        input logic u, input logic [15:0] d);
        @(posedge clk);
        #1;
        clr_n = c;
        load  = l;
        en    = e;
        up_d  = u;
        din   = d;
        @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("reset_cnt", 32'(cnt), 32'h0000);
        chk("reset_ovf", 32'(ovf), 32'h0);
        chk("reset_tc_up", 32'(tc), 32'h0);

        // Ten up edges
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
            chk("count10_tc", 32'(tc), 32'h0);
        end
        chk("count10_cnt", 32'(cnt), 32'h0010);

        // Reset with down direction: terminal at zero
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        chk("reset_tc_down", 32'(tc), 32'h1);
        chk("reset_co_down", 32'(co), 32'h0);

        // Full-range up wrap
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h9999);
        chk("load9999_cnt", 32'(cnt), 32'h9999);
        chk("load9999_ovf", 32'(ovf), 32'h0);
        chk("load9999_tc", 32'(tc), 32'h1);
        chk("load9999_co", 32'(co), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        chk("upwrap_cnt", 32'(cnt), 32'h0000);
        chk("upwrap_ovf", 32'(ovf), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        chk("upwrap_next_cnt", 32'(cnt), 32'h0001);
        chk("upwrap_next_ovf", 32'(ovf), 32'h0);

        // Load overrides a pending wrap; no ovf
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h9999);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0005);
        chk("load_over_en_cnt", 32'(cnt), 32'h0005);
        chk("load_over_en_ovf", 32'(ovf), 32'h0);

        // Down wrap from zero
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("downwrap_cnt", 32'(cnt), 32'h9999);
        chk("downwrap_ovf", 32'(ovf), 32'h1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("downwrap_next_cnt", 32'(cnt), 32'h9998);
        chk("downwrap_next_ovf", 32'(ovf), 32'h0);

        // Borrow across several digits
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("borrow_cnt", 32'(cnt), 32'h0999);

        // Saturating load, then hold
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h12F4);
        chk("satload_cnt", 32'(cnt), 32'h1294);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
        end
        chk("hold_cnt", 32'(cnt), 32'h1294);
        chk("hold_ovf", 32'(ovf), 32'h0);

        // Count to 0457, then reset against load and en
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0450);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        end
        chk("count457_cnt", 32'(cnt), 32'h0457);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h9999);
        chk("reset_dom_cnt", 32'(cnt), 32'h0000);
        chk("reset_dom_ovf", 32'(ovf), 32'h0);

        // Direction flips on the would-be wrap edge
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0199);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("dirflip_cnt", 32'(cnt), 32'h0198);
        chk("dirflip_ovf", 32'(ovf), 32'h0);

        // Mixed enable/direction near the top of range
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h9997);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 2) != 0), 16'h0000);
        end

        @(posedge clk);
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
